// File: rtl/waterloo_text_sequencer.sv
// Frame-rate animation controller for the gold text overlay: typewriter reveal,
// hold, blink and left-to-right wipe of a per-character visibility mask.
module waterloo_text_sequencer #(
    parameter int NUM_CHARS    = 12,
    parameter int CHAR_FRAMES  = 4,
    parameter int HOLD_FRAMES  = 60,
    parameter int BLINK_FRAMES = 8,
    parameter int BLINK_COUNT  = 3,
    parameter int LOOP         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic                 abort,
    output logic [NUM_CHARS-1:0] char_visible,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state
);

    localparam int MAX_CH      = (CHAR_FRAMES > HOLD_FRAMES) ? CHAR_FRAMES : HOLD_FRAMES;
    localparam int MAX_FRAMES  = (MAX_CH > BLINK_FRAMES) ? MAX_CH : BLINK_FRAMES;
    localparam int FCW         = $clog2(MAX_FRAMES + 1);
    localparam int BCW         = $clog2(2 * BLINK_COUNT + 1);

    localparam logic [FCW-1:0] CHAR_LAST  = FCW'(CHAR_FRAMES - 1);
    localparam logic [FCW-1:0] HOLD_LAST  = FCW'(HOLD_FRAMES - 1);
    localparam logic [FCW-1:0] BLINK_LAST = FCW'(BLINK_FRAMES - 1);
    localparam logic [BCW-1:0] BLINK_END  = BCW'(2 * BLINK_COUNT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REVEAL = 3'd1,
        HOLD   = 3'd2,
        BLINK  = 3'd3,
        WIPE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CHARS-1:0] mask_q, mask_d;
    logic [FCW-1:0]       frame_cnt_q, frame_cnt_d;
    logic [BCW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                 text_on_q, text_on_d;
    logic [NUM_CHARS-1:0] char_visible_q, char_visible_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        text_on_d   = text_on_q;
        done_d      = 1'b0;

        // abort outranks start and frame_tick in every state
        if (abort) begin
            state_d     = IDLE;
            mask_d      = '0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            text_on_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = REVEAL;
                        mask_d      = '0;
                        frame_cnt_d = '0;
                        blink_cnt_d = '0;
                        text_on_d   = 1'b1;
                    end
                end
                REVEAL: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == CHAR_LAST) begin
                            frame_cnt_d = '0;
                            mask_d      = (mask_q << 1) | NUM_CHARS'(1);
                            if (mask_d == '1)
                                state_d = HOLD;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_d     = BLINK;
                            frame_cnt_d = '0;
                            blink_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                        end
                    end
                end
                BLINK: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            frame_cnt_d = '0;
                            text_on_d   = ~text_on_q;
                            blink_cnt_d = blink_cnt_q + BCW'(1);
                            if (blink_cnt_d == BLINK_END) begin
                                state_d     = WIPE;
                                blink_cnt_d = '0;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                        end
                    end
                end
                WIPE: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == CHAR_LAST) begin
                            frame_cnt_d = '0;
                            mask_d      = mask_q << 1;
                            if (mask_d == '0) begin
                                done_d      = 1'b1;
                                text_on_d   = 1'b1;
                                blink_cnt_d = '0;
                                state_d     = (LOOP != 0) ? REVEAL : IDLE;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    mask_d      = '0;
                    frame_cnt_d = '0;
                    blink_cnt_d = '0;
                    text_on_d   = 1'b1;
                end
            endcase
        end

        busy_d         = (state_d != IDLE);
        char_visible_d = mask_q & {NUM_CHARS{text_on_q}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            frame_cnt_q    <= '0;
            blink_cnt_q    <= '0;
            text_on_q      <= 1'b1;
            char_visible_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            text_on_q      <= text_on_d;
            char_visible_q <= char_visible_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign char_visible = char_visible_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_waterloo_text_sequencer.sv
// Bench for waterloo_text_sequencer: directed walk through every phase plus
// randomized frame_tick/start/abort traffic against a tick-count reference model.
module tb_waterloo_text_sequencer;

    localparam int NC = 12;
    localparam int CF = 4;
    localparam int HF = 60;
    localparam int BF = 8;
    localparam int BC = 3;
    localparam int LP = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NC-1:0] char_visible;
    logic          busy;
    logic          done;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: phase number and frame ticks elapsed within that phase
    int m_phase = 0;
    int m_n     = 0;

    waterloo_text_sequencer #(
        .NUM_CHARS(NC), .CHAR_FRAMES(CF), .HOLD_FRAMES(HF),
        .BLINK_FRAMES(BF), .BLINK_COUNT(BC), .LOOP(LP)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .abort(abort),
        .char_visible(char_visible), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] m_mask();
        int k;
        k = m_n / CF;
        case (m_phase)
            1:       return NC'((1 << k) - 1);
            2, 3:    return {NC{1'b1}};
            4:       return NC'(((1 << NC) - 1) << k);
            default: return '0;
        endcase
    endfunction

    function automatic logic m_text_on();
        if (m_phase == 3)
            return ((m_n / BF) % 2) == 0;
        return 1'b1;
    endfunction

    // one clock: drive inputs, advance model, compare all outputs #1 after the edge
    task automatic cycle(input logic ft, input logic st, input logic ab);
        logic [NC-1:0] exp_vis;
        logic          exp_done;
        frame_tick = ft;
        start      = st;
        abort      = ab;
        @(posedge clk);
        #1;
        exp_vis  = m_mask() & {NC{m_text_on()}};
        exp_done = 1'b0;
        if (ab) begin
            m_phase = 0;
            m_n     = 0;
        end else begin
            case (m_phase)
                0: if (st) begin m_phase = 1; m_n = 0; end
                1: if (ft) begin
                    m_n++;
                    if (m_n == NC * CF) begin m_phase = 2; m_n = 0; end
                end
                2: if (ft) begin
                    m_n++;
                    if (m_n == HF) begin m_phase = 3; m_n = 0; end
                end
                3: if (ft) begin
                    m_n++;
                    if (m_n == 2 * BC * BF) begin m_phase = 4; m_n = 0; end
                end
                4: if (ft) begin
                    m_n++;
                    if (m_n == NC * CF) begin
                        exp_done = 1'b1;
                        m_phase  = (LP != 0) ? 1 : 0;
                        m_n      = 0;
                    end
                end
                default: begin m_phase = 0; m_n = 0; end
            endcase
        end
        chk("char_visible", 32'(char_visible), 32'(exp_vis));
        chk("state", 32'(state), 32'(m_phase));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(exp_done));
        frame_tick = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
    endtask

    // n frame ticks, each followed by a quiet cycle so char_visible has caught up
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vis", 32'(char_visible), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        ticks(3);

        // reveal
        cycle(1'b0, 1'b1, 1'b0);
        ticks(4);
        chk("reveal_4", 32'(char_visible), 32'h001);
        ticks(4);
        chk("reveal_8", 32'(char_visible), 32'h003);
        ticks(40);
        chk("reveal_48", 32'(char_visible), 32'hFFF);
        chk("hold_state", 32'(state), 32'd2);

        // hold, with a stray start that must be ignored
        ticks(10);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        ticks(49);
        chk("blink_state", 32'(state), 32'd3);

        // blink
        ticks(8);
        chk("blink_off", 32'(char_visible), 32'h000);
        ticks(8);
        chk("blink_on", 32'(char_visible), 32'hFFF);
        ticks(32);
        chk("wipe_state", 32'(state), 32'd4);

        // wipe and loop back
        ticks(4);
        chk("wipe_4", 32'(char_visible), 32'hFFE);
        ticks(43);
        cycle(1'b1, 1'b0, 1'b0);
        chk("wipe_done", 32'(done), 32'd1);
        chk("loop_state", 32'(state), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("wipe_end_vis", 32'(char_visible), 32'h000);

        // async reset mid-reveal takes effect before the next edge
        ticks(9);
        rst = 1'b1;
        #2;
        chk("amid_vis", 32'(char_visible), 32'h0);
        chk("amid_state", 32'(state), 32'h0);
        chk("amid_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_phase = 0;
        m_n     = 0;
        ticks(6);
        chk("post_rst_idle", 32'(state), 32'h0);

        // start and frame_tick together: that tick does not count
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        ticks(3);
        chk("same_cycle_3", 32'(char_visible), 32'h000);
        ticks(1);
        chk("same_cycle_4", 32'(char_visible), 32'h001);

        // abort in blink while text is off, then clean restart
        ticks(44 + 60 + 8);
        chk("pre_abort_vis", 32'(char_visible), 32'h000);
        chk("pre_abort_state", 32'(state), 32'd3);
        cycle(1'b0, 1'b0, 1'b1);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_vis", 32'(char_visible), 32'h000);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(3);
        chk("restart_3", 32'(char_visible), 32'h000);
        ticks(1);
        chk("restart_4", 32'(char_visible), 32'h001);

        // randomized traffic
        for (int i = 0; i < 20000; i++)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2999) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
